// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer handshake bundle for sync_fifo.
interface sync_fifo_if #(
  parameter int WIDTH        = 32,
  parameter int ADDRESS_SIZE = 4
);
  logic                    flush;
  logic                    enqueue;
  logic [WIDTH-1:0]        data_in;
  logic                    dequeue;
  logic [WIDTH-1:0]        data_out;
  logic                    data_out_valid;
  logic                    full;
  logic                    empty;
  logic [ADDRESS_SIZE:0]   count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output flush, enqueue, data_in, dequeue,
    input  data_out, data_out_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  flush, enqueue, data_in, dequeue,
    output data_out, data_out_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read port and exact registered status.
module sync_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int ADDRESS_SIZE = 4
) (
  input logic         clock,
  input logic         reset_n,
  sync_fifo_if.slave  bus
);
  localparam int CW = ADDRESS_SIZE + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]        r_mem [DEPTH];
  logic [ADDRESS_SIZE-1:0] r_wptr, r_rptr;
  logic [CW-1:0]           r_count;
  logic                    r_full, r_empty, r_valid, r_ovf, r_unf;
  logic [WIDTH-1:0]        r_dout;

  logic          w_enq_ok, w_deq_ok, w_wr, w_rd;
  logic [CW-1:0] w_count_nxt;

  // A full FIFO is never empty, so an enqueue paired with a dequeue always frees its slot.
  always_comb begin
    w_enq_ok    = bus.enqueue & (!r_full | bus.dequeue);
    w_deq_ok    = bus.dequeue & !r_empty;
    w_wr        = w_enq_ok & !bus.flush;
    w_rd        = w_deq_ok & !bus.flush;
    w_count_nxt = bus.flush ? '0 : r_count + CW'(w_wr) - CW'(w_rd);
  end

  // Storage is not reset; the read below sees the old word when both ports hit one slot.
  always_ff @(posedge clock)
    if (w_wr) r_mem[r_wptr] <= bus.data_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_wptr  <= bus.flush ? '0 : r_wptr + ADDRESS_SIZE'(w_wr);
      r_rptr  <= bus.flush ? '0 : r_rptr + ADDRESS_SIZE'(w_rd);
      r_count <= w_count_nxt;
      r_full  <= w_count_nxt == FULL_CNT;
      r_empty <= w_count_nxt == '0;
      r_valid <= w_rd;
      r_ovf   <= !bus.flush & bus.enqueue & !w_enq_ok;
      r_unf   <= !bus.flush & bus.dequeue & !w_deq_ok;
      if (w_rd) r_dout <= r_mem[r_rptr];
    end
  end

  assign bus.data_out       = r_dout;
  assign bus.data_out_valid = r_valid;
  assign bus.full           = r_full;
  assign bus.empty          = r_empty;
  assign bus.count          = r_count;
  assign bus.overflow       = r_ovf;
  assign bus.underflow      = r_unf;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed plus random stimulus against a queue-based FIFO model.
module tb_sync_fifo;
  localparam int W = 32, D = 16, A = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sync_fifo_if #(.WIDTH(W), .ADDRESS_SIZE(A)) bus ();
  sync_fifo #(.WIDTH(W), .DEPTH(D), .ADDRESS_SIZE(A)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_valid, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic check_all(input string p);
    chk({p, "_count"}, 64'(bus.count), 64'(q.size()));
    chk({p, "_full"}, 64'(bus.full), 64'(q.size() == D));
    chk({p, "_empty"}, 64'(bus.empty), 64'(q.size() == 0));
    chk({p, "_valid"}, 64'(bus.data_out_valid), 64'(m_valid));
    chk({p, "_ovf"}, 64'(bus.overflow), 64'(m_ovf));
    chk({p, "_unf"}, 64'(bus.underflow), 64'(m_unf));
    chk({p, "_dout"}, 64'(bus.data_out), 64'(m_dout));
  endtask

  // Called at a negedge: drive, take one posedge, update model, check at next negedge.
  task automatic step(input string p, input logic fl, input logic en, input logic [W-1:0] din,
                      input logic de);
    bit ok_e, ok_d;
    bus.flush   = fl;
    bus.enqueue = en;
    bus.data_in = din;
    bus.dequeue = de;
    ok_e = en && (q.size() < D || de);
    ok_d = de && q.size() > 0;
    @(posedge clock);
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      if (ok_d) m_dout = q.pop_front();
      if (ok_e) q.push_back(din);
      m_valid = ok_d;
      m_ovf   = en && !ok_e;
      m_unf   = de && !ok_d;
    end
    @(negedge clock);
    check_all(p);
  endtask

  initial begin
    int pe, pd;
    bus.flush = 0; bus.enqueue = 0; bus.data_in = '0; bus.dequeue = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("rst");
    reset_n = 1'b1;
    step("idle", 0, 0, '0, 0);
    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) step("fill", 0, 1, W'(32'h11 + i), 0);
    step("ovf17", 0, 1, 32'hFF, 0);
    for (int i = 0; i < 16; i++) step("drain", 0, 0, '0, 1);
    // Dequeue on empty with concurrent enqueue.
    step("unf_enq", 0, 1, 32'hAB, 1);
    step("get_ab", 0, 0, '0, 1);
    // Sustained traffic at full across pointer wrap.
    for (int i = 0; i < 16; i++) step("fill2", 0, 1, W'(32'h100 + i), 0);
    for (int i = 0; i < 40; i++) step("stream", 0, 1, W'(32'h200 + i), 1);
    for (int i = 0; i < 11; i++) step("to5", 0, 0, '0, 1);
    step("flush", 1, 1, 32'hDEAD, 1);
    step("post_fl", 0, 0, '0, 1);
    step("fl_enq", 0, 1, 32'h55, 0);
    step("fl_deq", 0, 0, '0, 1);
    // Asynchronous reset during an in-flight read at count 7.
    for (int i = 0; i < 8; i++) step("fill7", 0, 1, W'(32'h300 + i), 0);
    bus.enqueue = 0;
    bus.dequeue = 1;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("arst");
    #1 reset_n = 1'b1;
    @(negedge clock);
    check_all("arst_rel");
    step("rt_enq", 0, 1, 32'h77, 0);
    step("rt_pair", 0, 1, 32'h78, 1);
    step("rt_deq", 0, 0, '0, 1);
    // Random traffic with varying bias.
    for (int ph = 0; ph < 4; ph++) begin
      pe = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      pd = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      for (int i = 0; i < 100; i++)
        step("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 99) < pe, $urandom(),
             $urandom_range(0, 99) < pd);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
